// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshakes of the ALU issue stage.
// slave is the sequencer side, master the producer/consumer side.
interface alu_cmd_sequencer_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [3:0]    cmd_op;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [3:0]    res_op;
  logic          res_err;

  modport slave (
    input  cmd_valid,
    input  cmd_a,
    input  cmd_b,
    input  cmd_op,
    input  res_ready,
    output cmd_ready,
    output res_valid,
    output res_data,
    output res_op,
    output res_err
  );

  modport master (
    output cmd_valid,
    output cmd_a,
    output cmd_b,
    output cmd_op,
    output res_ready,
    input  cmd_ready,
    input  res_valid,
    input  res_data,
    input  res_op,
    input  res_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: command FIFO, registered ALU
// operands, and a filtered valid/ready result register.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_cmd_sequencer_if.slave     bus,
  output logic [DW-1:0]          alu_in1,
  output logic [DW-1:0]          alu_in2,
  output logic [3:0]             alu_oper,
  input  logic [DW-1:0]          alu_y,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DW-1:0] mem_a  [DEPTH];
  logic [DW-1:0] mem_b  [DEPTH];
  logic [3:0]    mem_op [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;
  logic          hs;
  logic          empty;
  logic          div_like;
  logic          err;

  assign bus.cmd_ready = (count < FULL);
  assign empty = (count == '0);
  assign push  = bus.cmd_valid & bus.cmd_ready;
  assign hs    = bus.res_valid & bus.res_ready;

  // Divide and modulo by zero have no defined ALU result.
  assign div_like = (alu_oper == 4'b0011)
                  | (alu_oper == 4'b0100);
  assign err = alu_oper[3]
             | (div_like & (alu_in2 == '0));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (hs) begin
          pop      = !empty;
          state_nx = empty ? IDLE : EXEC;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr]  <= bus.cmd_a;
      mem_b[wptr]  <= bus.cmd_b;
      mem_op[wptr] <= bus.cmd_op;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case (1'b1)
        push & !pop: count <= count + CW'(1);
        pop & !push: count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_oper <= '0;
    end else if (pop) begin
      alu_in1  <= mem_a[rptr];
      alu_in2  <= mem_b[rptr];
      alu_oper <= mem_op[rptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_op    <= '0;
      bus.res_err   <= 1'b0;
    end else if (state == EXEC) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= err ? '0 : alu_y;
      bus.res_op    <= alu_oper;
      bus.res_err   <= err;
    end else if (hs) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural
// ALU closing the loop on alu_in1/alu_in2/alu_oper.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [3:0] alu_oper;
  logic [7:0] alu_y;
  logic [2:0] count;

  int checks;
  int errors;

  logic [7:0] rd   [16];
  logic [3:0] rop  [16];
  logic       rerr [16];
  int         got;
  int         acc;

  alu_cmd_sequencer_if #(.DW(8)) bus ();

  alu_cmd_sequencer #(.DEPTH(4), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_oper (alu_oper),
    .alu_y    (alu_y),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_y = 8'h00;
    case (alu_oper)
      4'b0000: alu_y = alu_in1 + alu_in2;
      4'b0001: alu_y = alu_in1 - alu_in2;
      4'b0010: alu_y = alu_in1 * alu_in2;
      4'b0011: alu_y = (alu_in2 == 0) ? 8'hFF : alu_in1 / alu_in2;
      4'b0100: alu_y = (alu_in2 == 0) ? 8'hFF : alu_in1 % alu_in2;
      4'b0101: alu_y = alu_in1 & alu_in2;
      4'b0110: alu_y = alu_in1 << alu_in2;
      4'b0111: alu_y = alu_in1 >> alu_in2;
      default: alu_y = alu_in1 ^ alu_in2;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op);
    logic r;
    bit   ok;
    ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    for (int i = 0; i < 40; i++) begin
      r = bus.cmd_ready;
      @(negedge clk);
      if (r) begin
        ok = 1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: got timeout want accepted");
    end
  endtask

  task automatic drain(input int n);
    bit drop;
    drop = 0;
    got = 0;
    acc = 0;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (bus.res_valid && got < 16) begin
        rd[got] = bus.res_data;
        rop[got] = bus.res_op;
        rerr[got] = bus.res_err;
        got++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc++;
        drop = 1;
      end
      @(negedge clk);
      if (drop) begin
        bus.cmd_valid = 1'b0;
        drop = 0;
      end
      if (got >= n) break;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL drain_count: got %0d want %0d", got, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", bus.cmd_ready);
    end
    checks++;
    if ({bus.res_valid, bus.res_err, count} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b%b %0d want 0",
               bus.res_valid, bus.res_err, count);
    end
    checks++;
    if ({alu_in1, alu_in2, alu_oper, bus.res_data, bus.res_op}
        !== 32'h0) begin
      errors++;
      $display("FAIL rst_data: got %h %h %h %h %h want 0", alu_in1,
               alu_in2, alu_oper, bus.res_data, bus.res_op);
    end
  endtask

  task automatic test_basic;
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 8'd5;
    bus.cmd_b = 8'd3;
    bus.cmd_op = 4'b0000;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL basic_cnt: got %0d want 1", count);
    end
    @(negedge clk);
    checks++;
    if ({alu_in1, alu_in2, bus.res_valid} !== {8'd5, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_issue: got %0d %0d %b want 5 3 0",
               alu_in1, alu_in2, bus.res_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_err, bus.res_op}
        !== {1'b1, 8'd8, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL basic_res: got v%b d%0d e%b o%h want v1 d8 e0 o0",
               bus.res_valid, bus.res_data, bus.res_err, bus.res_op);
    end
    @(negedge clk);
    checks++;
    if ({bus.res_valid, count} !== 4'b0) begin
      errors++;
      $display("FAIL basic_clear: got v%b c%0d want v0 c0",
               bus.res_valid, count);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.res_valid, alu_in1} !== {1'b0, 8'd5}) begin
      errors++;
      $display("FAIL basic_hold: got v%b a%0d want v0 a5",
               bus.res_valid, alu_in1);
    end
  endtask

  task automatic test_errors;
    logic [3:0] eop [3];
    eop[0] = 4'b0011;
    eop[1] = 4'b0100;
    eop[2] = 4'b1001;
    bus.res_ready = 1'b0;
    push_cmd(8'd7, 8'd0, 4'b0011);
    push_cmd(8'd7, 8'd0, 4'b0100);
    push_cmd(8'd1, 8'd1, 4'b1001);
    drain(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd[i], rerr[i], rop[i]} !== {8'd0, 1'b1, eop[i]}) begin
        errors++;
        $display("FAIL err_res%0d: got d%0d e%b o%h want d0 e1 o%h",
                 i, rd[i], rerr[i], rop[i], eop[i]);
      end
    end
  endtask

  task automatic test_full;
    logic [7:0] exp [6];
    exp[0] = 8'd6;
    exp[1] = 8'd2;
    exp[2] = 8'd4;
    exp[3] = 8'd6;
    exp[4] = 8'd8;
    exp[5] = 8'd10;
    bus.res_ready = 1'b0;
    push_cmd(8'd10, 8'd4, 4'b0001);
    for (int i = 1; i <= 4; i++) push_cmd(8'(i), 8'(i), 4'b0000);
    checks++;
    if ({bus.cmd_ready, count} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL full_flag: got r%b c%0d want r0 c4",
               bus.cmd_ready, count);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 8'd5;
    bus.cmd_b = 8'd5;
    bus.cmd_op = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.res_data, count, bus.cmd_ready}
          !== {1'b1, 8'd6, 3'd4, 1'b0}) begin
        errors++;
        $display("FAIL full_hold: got v%b d%0d c%0d r%b want v1 d6 c4 r0",
                 bus.res_valid, bus.res_data, count, bus.cmd_ready);
      end
    end
    drain(6);
    checks++;
    if (acc != 1) begin
      errors++;
      $display("FAIL full_accept6: got %0d want 1", acc);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({rd[i], rerr[i]} !== {exp[i], 1'b0}) begin
        errors++;
        $display("FAIL full_res%0d: got %0d e%b want %0d e0",
                 i, rd[i], rerr[i], exp[i]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({count, bus.res_valid} !== 4'b0) begin
      errors++;
      $display("FAIL full_empty: got c%0d v%b want c0 v0",
               count, bus.res_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    exp[0] = 8'd15;
    exp[1] = 8'd12;
    exp[2] = 8'd14;
    bus.res_ready = 1'b0;
    push_cmd(8'd1, 8'd2, 4'b0000);
    push_cmd(8'd20, 8'd5, 4'b0001);
    push_cmd(8'd3, 8'd4, 4'b0010);
    checks++;
    if ({count, bus.res_valid, bus.res_data} !== {3'd2, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL b2b_pre: got c%0d v%b d%0d want c2 v1 d3",
               count, bus.res_valid, bus.res_data);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 8'd100;
    bus.cmd_b = 8'd7;
    bus.cmd_op = 4'b0011;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL b2b_cnt: got %0d want 2", count);
    end
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_data} !== {1'b1, 8'd15}) begin
      errors++;
      $display("FAIL b2b_head: got v%b d%0d want v1 d15",
               bus.res_valid, bus.res_data);
    end
    drain(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd[i] !== exp[i]) begin
        errors++;
        $display("FAIL b2b_res%0d: got %0d want %0d", i, rd[i], exp[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(8'(i), 8'd1, 4'b0000);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if ({count, bus.res_valid} !== {3'd3, 1'b0}) begin
      errors++;
      $display("FAIL ar_exec: got c%0d v%b want c3 v0",
               count, bus.res_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({count, bus.res_valid, bus.res_err, bus.res_data, bus.res_op,
         alu_in1, alu_in2, alu_oper} !== 40'h0) begin
      errors++;
      $display("FAIL ar_clear: got c%0d v%b a%0d d%0d want all 0",
               count, bus.res_valid, alu_in1, bus.res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({bus.res_valid, count, bus.cmd_ready} !== {1'b0, 3'd0, 1'b1}) begin
        errors++;
        $display("FAIL ar_quiet: got v%b c%0d r%b want v0 c0 r1",
                 bus.res_valid, count, bus.cmd_ready);
      end
    end
    push_cmd(8'd2, 8'd3, 4'b0010);
    drain(1);
    checks++;
    if ({rd[0], rerr[0]} !== {8'd6, 1'b0}) begin
      errors++;
      $display("FAIL ar_mul: got %0d e%b want 6 e0", rd[0], rerr[0]);
    end
  endtask

  task automatic test_shift;
    logic [7:0] exp [3];
    exp[0] = 8'd8;
    exp[1] = 8'd1;
    exp[2] = 8'd0;
    bus.res_ready = 1'b0;
    push_cmd(8'd1, 8'd3, 4'b0110);
    push_cmd(8'd128, 8'd7, 4'b0111);
    push_cmd(8'd16, 8'd16, 4'b0010);
    drain(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd[i], rerr[i]} !== {exp[i], 1'b0}) begin
        errors++;
        $display("FAIL shift_res%0d: got %0d e%b want %0d e0",
                 i, rd[i], rerr[i], exp[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_errors();
    test_full();
    test_back_to_back();
    test_async_reset();
    test_shift();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
